// File: rtl/srdl_counter_field.sv
// Registered SystemRDL field: sw/hw access, side effects, up/down counter.
// Optional SRDL_FIELD_PARITY_EN adds a stored parity bit and parity_err.
module srdl_counter_field #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0,
  parameter int unsigned      SW_MODE     = 2,
  parameter bit               HW_WR       = 1'b1,
  parameter bit               RCLR        = 1'b0,
  parameter bit               RSET        = 1'b0,
  parameter bit               WOCLR       = 1'b0,
  parameter bit               WOSET       = 1'b0,
  parameter bit               SINGLEPULSE = 1'b0,
  parameter bit               COUNTER     = 1'b0,
  parameter int unsigned      INCRWIDTH   = 1,
  parameter int unsigned      DECRWIDTH   = 1,
  parameter bit               SATURATE    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sw_acc,
  input  logic                 sw_rd,
  input  logic                 sw_wr,
  input  logic [WIDTH-1:0]     sw_wdata,
  input  logic                 hw_we,
  input  logic [WIDTH-1:0]     hw_wdata,
  input  logic                 hwclr,
  input  logic                 hwset,
  input  logic                 incr,
  input  logic [INCRWIDTH-1:0] incrvalue,
  input  logic                 decr,
  input  logic [DECRWIDTH-1:0] decrvalue,
  input  logic [WIDTH-1:0]     incrsat_val,
  input  logic [WIDTH-1:0]     decrsat_val,
  input  logic [WIDTH-1:0]     incrthresh_val,
  input  logic [WIDTH-1:0]     decrthresh_val,
  output logic [WIDTH-1:0]     q,
  output logic                 swmod,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 incrsaturate,
  output logic                 decrsaturate,
  output logic                 incrthreshold,
`ifdef SRDL_FIELD_PARITY_EN
  input  logic                 inj_par,
  output logic                 parity_err,
`endif
  output logic                 decrthreshold
);

  localparam int unsigned NW = WIDTH + 2;
  localparam bit SW_WR_EN = (SW_MODE != 0);

  logic [WIDTH-1:0]     r_q;
  logic                 r_swmod;
  logic                 r_ovf;
  logic                 r_unf;
  logic [WIDTH-1:0]     w_q_nxt;
  logic                 w_swmod_nxt;
  logic                 w_cnt_sel;
  logic signed [NW-1:0] w_inc;
  logic signed [NW-1:0] w_dec;
  logic signed [NW-1:0] w_n;
  logic                 w_ovf;
  logic                 w_unf;
  logic                 w_sat_hi;
  logic                 w_sat_lo;
  logic                 w_sw_wr;
  logic                 w_rd_fx;
  logic                 w_cnt_act;

  assign w_sw_wr   = sw_acc & sw_wr & SW_WR_EN;
  assign w_rd_fx   = sw_acc & sw_rd & ~sw_wr & (RCLR | RSET);
  assign w_cnt_act = COUNTER & (incr | decr);

  // Zero-extended operands; two spare bits hold the sign and the carry.
  assign w_inc = incr ? $signed({{(NW-INCRWIDTH){1'b0}}, incrvalue}) : '0;
  assign w_dec = decr ? $signed({{(NW-DECRWIDTH){1'b0}}, decrvalue}) : '0;
  assign w_n   = $signed({2'b00, r_q}) + w_inc - w_dec;

  assign w_unf    = w_n[NW-1];
  assign w_ovf    = ~w_n[NW-1] & w_n[WIDTH];
  assign w_sat_hi = w_ovf | (w_n > $signed({2'b00, incrsat_val}));
  assign w_sat_lo = w_unf | (w_n < $signed({2'b00, decrsat_val}));

  always_comb begin
    w_q_nxt     = r_q;
    w_swmod_nxt = 1'b0;
    w_cnt_sel   = 1'b0;
    if (hwclr) begin
      w_q_nxt = '0;
    end else if (hwset) begin
      w_q_nxt = '1;
    end else if (w_sw_wr) begin
      w_swmod_nxt = 1'b1;
      if (WOCLR)      w_q_nxt = r_q & ~sw_wdata;
      else if (WOSET) w_q_nxt = r_q | sw_wdata;
      else            w_q_nxt = sw_wdata;
    end else if (hw_we & HW_WR) begin
      w_q_nxt = hw_wdata;
    end else if (w_cnt_act) begin
      w_cnt_sel = 1'b1;
      // Upper clamp is checked first so it wins over a crossed lower clamp.
      if (SATURATE && w_sat_hi)      w_q_nxt = incrsat_val;
      else if (SATURATE && w_sat_lo) w_q_nxt = decrsat_val;
      else                           w_q_nxt = w_n[WIDTH-1:0];
    end else if (w_rd_fx) begin
      w_swmod_nxt = 1'b1;
      w_q_nxt     = RCLR ? '0 : '1;
    end else if (SINGLEPULSE && (|r_q)) begin
      w_q_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q     <= RESET_VAL;
      r_swmod <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_q     <= w_q_nxt;
      r_swmod <= w_swmod_nxt;
      r_ovf   <= w_cnt_sel & w_ovf;
      r_unf   <= w_cnt_sel & w_unf;
    end
  end

`ifdef SRDL_FIELD_PARITY_EN
  logic r_par;
  logic r_perr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_par  <= ^RESET_VAL;
      r_perr <= 1'b0;
    end else begin
      r_par  <= (^w_q_nxt) ^ inj_par;
      r_perr <= w_sw_wr ? 1'b0 : (r_perr | (r_par ^ (^r_q)));
    end
  end

  assign parity_err = r_perr;
`endif

  assign q             = r_q;
  assign swmod         = r_swmod;
  assign overflow      = r_ovf;
  assign underflow     = r_unf;
  assign incrsaturate  = (r_q == incrsat_val);
  assign decrsaturate  = (r_q == decrsat_val);
  assign incrthreshold = (r_q >= incrthresh_val);
  assign decrthreshold = (r_q <= decrthresh_val);

endmodule

// File: doc/srdl_counter_field.md
Name: srdl_counter_field

Overview:
Registered, parametrised SystemRDL field that holds the state for one field. It has configurable software and hardware access semantics, read/write side effects and a full up/down counter with saturation and threshold flags. It is instantiated once per field by the generated register block, between the address-decode/bus-access logic and the hardware interface. It generalises the earlier combinational field next-state logic to a clocked block with variable increment/decrement widths, explicit precedence and registered event outputs.

Parameters:
WIDTH, 8, field width in bits (1..64)
RESET_VAL, 0, value of q after reset
SW_MODE, 2, 0=r, 1=w, 2=rw (sw write ignored when 0)
HW_WR, 1, 1 = hardware write port active
RCLR, 0, software read clears field
RSET, 0, software read sets field to all ones (RCLR takes priority if both are set)
WOCLR, 0, software write clears bits written as 1
WOSET, 0, software write sets bits written as 1 (WOCLR takes priority)
SINGLEPULSE, 0, field returns to 0 one cycle after any nonzero value
COUNTER, 0, enable counter logic
INCRWIDTH, 1, width of incrvalue (<= WIDTH)
DECRWIDTH, 1, width of decrvalue (<= WIDTH)
SATURATE, 1, 1 = clamp at saturate values; 0 = wrap modulo 2^WIDTH

Ports:
clk  in  1  field clock
rst  in  1  synchronous active-high reset
sw_acc  in  1  software access strobe for this field's register
sw_rd  in  1  software read (qualified by sw_acc)
sw_wr  in  1  software write (qualified by sw_acc)
sw_wdata  in  WIDTH  software write data
hw_we  in  1  hardware write enable
hw_wdata  in  WIDTH  hardware write data
hwclr  in  1  hardware clear
hwset  in  1  hardware set to all ones
incr  in  1  counter increment strobe
incrvalue  in  INCRWIDTH  increment amount
decr  in  1  counter decrement strobe
decrvalue  in  DECRWIDTH  decrement amount
incrsat_val  in  WIDTH  upper saturation value
decrsat_val  in  WIDTH  lower saturation value
incrthresh_val  in  WIDTH  upper threshold
decrthresh_val  in  WIDTH  lower threshold
q  out  WIDTH  field value (registered)
swmod  out  1  registered pulse: field was modified by software last cycle
overflow  out  1  registered pulse
underflow  out  1  registered pulse
incrsaturate  out  1  q == incrsat_val
decrsaturate  out  1  q == decrsat_val
incrthreshold  out  1  q >= incrthresh_val
decrthreshold  out  1  q <= decrthresh_val

Behaviour:
- Reset: clk-edge with rst=1 gives q=RESET_VAL and swmod=overflow=underflow=0. Combinational flags follow q. Reset overrides every other input in the same cycle.
- All state updates occur on the rising clk edge. q changes one cycle after the qualifying input.
- Precedence, highest first; only the highest active source determines q_next:
  1. hwclr: q_next = 0.
  2. hwset: q_next = all ones.
  3. sw write (sw_acc & sw_wr & SW_MODE!=0): WOCLR gives q & ~wdata; WOSET gives q | wdata; otherwise wdata.
  4. hw_we & HW_WR: q_next = hw_wdata.
  5. Counter (COUNTER=1, incr|decr): see the arithmetic rules below.
  6. Read side effect (sw_acc & sw_rd & ~sw_wr): RCLR gives 0; RSET gives all ones.
  7. SINGLEPULSE with q != 0: q_next = 0.
  8. Otherwise hold.
- swmod = 1 for one cycle after case 3 or case 6 takes effect.
- Counter arithmetic:
  - Compute n = q + (incr ? incrvalue : 0) - (decr ? decrvalue : 0) in signed WIDTH+2 bits, with zero-extended operands.
  - If n > 2^WIDTH-1: overflow pulses next cycle.
  - If n < 0: underflow pulses next cycle.
  - Simultaneous incr and decr use only the net result; for example, net 0 raises no flag.
- SATURATE=1:
  - If overflow or n > incrsat_val, q_next = incrsat_val.
  - Else if underflow or n < decrsat_val, q_next = decrsat_val.
  - Otherwise q_next = n[WIDTH-1:0].
- SATURATE=0: q_next = n[WIDTH-1:0] (wrap). Saturate inputs are ignored, but the comparator flags still drive.
- Counter events lost to higher-precedence sources do not raise overflow or underflow.
- If decrsat_val > incrsat_val, incrsat_val wins (the upper clamp is evaluated first).

Optional Feature:
SRDL_FIELD_PARITY_EN
- Defined: the block stores an extra even-parity bit, updated with every q write. It adds output parity_err (1 bit, registered, reset 0), which asserts and stays sticky until rst or a software write whenever the stored parity != ^q. For test, port inj_par (1 bit) inverts the stored parity bit on the next update.
- Undefined: no parity storage and no parity_err or inj_par ports.

Test Plan:
- Reset, then hold: WIDTH=8, RESET_VAL=8'h5A, rst for 2 cycles -> q=8'h5A, swmod/overflow/underflow=0; no inputs for 10 cycles -> q stays 8'h5A.
- Saturating up-count: COUNTER=1, SATURATE=1, INCRWIDTH=4, incrsat_val=8'hF0, q=8'hE8, incr with incrvalue=4'hC -> q=8'hF0 next cycle, no overflow. From q=8'hFC, incrsat_val=8'hFF, incrvalue=8 -> q=8'hFF, overflow pulses exactly one cycle.
- Wrap and net update: SATURATE=0, q=8'h02, decr decrvalue=3 -> q=8'hFF, underflow=1. Next cycle incr=1 (value 1) and decr=1 (value 1) -> q=8'hFF, no flags.
- Precedence: q=8'h10; same cycle hw_we (hw_wdata=8'h33), sw write 8'h44, incr -> q=8'h44, swmod=1. Next cycle hwclr with sw write 8'h55 -> q=8'h00, swmod=0.
- Write and read side effects: WOCLR=1, q=8'hFF, sw write 8'h0F -> q=8'hF0. Then RCLR=1 build, sw read with incr active -> q=incremented value (counter wins), swmod=0. Sw read alone -> q=0, swmod=1.
- Singlepulse and thresholds: SINGLEPULSE=1, sw write 8'h01 -> q=8'h01 for one cycle, then 8'h00. incrthresh_val=8'h01 -> incrthreshold high only during that cycle. decrthresh_val=0 -> decrthreshold high when q=0.
